// File: rtl/cntr_pkg.sv
// Shared encodings for the up/down timer: terminal-count mode codes and FSM states.
package cntr_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // One counting step modulo 2^WIDTH in the requested direction.
  function automatic logic [31:0] step_count(input logic [31:0] value, input logic up);
    return up ? value + 32'd1 : value - 32'd1;
  endfunction

endpackage

// File: rtl/cntr_prescaler.sv
// Prescaler: emits one tick every prescale+1 running cycles; holds its count when idle.
module cntr_prescaler #(
  parameter int PSC_W = 4
) (
  input  logic             clock,
  input  logic             start,
  input  logic             run,
  input  logic             clr,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] psc_reg;

  // Compare is live, so a new prescale value applies at the very next compare.
  assign tick = run && (psc_reg == prescale);

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      psc_reg <= '0;
    end else if (clr) begin
      psc_reg <= '0;
    end else if (run) begin
      psc_reg <= tick ? '0 : psc_reg + PSC_W'(1);
    end
  end

endmodule

// File: rtl/updown_timer.sv
// Programmable up/down counter/timer with prescaler, wrap/reload/one-shot terminal
// behaviour, synchronous load and a one-cycle terminal-count pulse.
module updown_timer
  import cntr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               PSC_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             start,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             busy,
  output logic             halted
);

  state_t           state_reg;
  logic [WIDTH-1:0] data_reg;
  logic             tc_reg;
  logic             busy_reg;
  logic             halted_reg;

  logic             run;
  logic             tick;
  logic             terminal;
  logic [WIDTH-1:0] stepped;

  assign run      = (state_reg == S_RUN) && en;
  assign terminal = dir ? (data_reg == {WIDTH{1'b1}}) : (data_reg == '0);
  assign stepped  = WIDTH'(step_count(32'(data_reg), dir));

  // Load restarts the prescale interval so the first tick after a load is a full period away.
  cntr_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clock   (clock),
    .start   (start),
    .run     (run),
    .clr     (load),
    .prescale(prescale),
    .tick    (tick)
  );

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      state_reg  <= S_IDLE;
      data_reg   <= RESET_VAL;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      tc_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (en) begin
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!en) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else if (!load && tick && terminal && mode == MODE_ONESHOT) begin
            state_reg  <= S_HALT;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
          end
        end
        S_HALT: begin
          if (load) begin
            state_reg  <= S_IDLE;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          busy_reg   <= 1'b0;
          halted_reg <= 1'b0;
        end
      endcase

      // Load wins over a coincident tick, which also swallows a terminal pulse.
      if (load) begin
        data_reg <= load_val;
      end else if (tick) begin
        if (terminal) begin
          tc_reg <= 1'b1;
          case (mode)
            MODE_RELOAD:  data_reg <= load_val;
            MODE_ONESHOT: data_reg <= data_reg;
            default:      data_reg <= stepped;
          endcase
        end else begin
          data_reg <= stepped;
        end
      end
    end
  end

  assign data   = data_reg;
  assign tc     = tc_reg;
  assign busy   = busy_reg;
  assign halted = halted_reg;

endmodule

// File: tb/tb_updown_timer.sv
// Self-checking bench for updown_timer: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model.
module tb_updown_timer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clock = 1'b0;
  logic       start;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] prescale;
  logic [7:0] data;
  logic       tc;
  logic       busy;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_data;
  int m_psc;
  int m_st;
  int m_tc;

  updown_timer dut (
    .clock   (clock),
    .start   (start),
    .en      (en),
    .dir     (dir),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .prescale(prescale),
    .data    (data),
    .tc      (tc),
    .busy    (busy),
    .halted  (halted)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_data = 255;
    m_psc  = 0;
    m_st   = M_IDLE;
    m_tc   = 0;
  endtask

  // Applies the timer's rules for one rising edge using the inputs currently driven.
  task automatic model_next();
    bit running, tk, at_end;
    int nst, nd, npsc, ntc, delta;
    if (start) begin
      model_reset();
      return;
    end
    running = (m_st == M_RUN) && en;
    tk      = running && (m_psc == int'(prescale));
    nst     = m_st;
    if (m_st == M_HALT) nst = load ? M_IDLE : M_HALT;
    else                nst = en ? M_RUN : M_IDLE;
    nd   = m_data;
    npsc = m_psc;
    ntc  = 0;
    if (load) begin
      nd   = int'(load_val);
      npsc = 0;
    end else begin
      if (running) npsc = tk ? 0 : (m_psc + 1) % 16;
      if (tk) begin
        delta  = dir ? 1 : -1;
        at_end = dir ? (m_data == 255) : (m_data == 0);
        if (at_end) begin
          ntc = 1;
          if (mode == 2'd1)      nd = int'(load_val);
          else if (mode == 2'd2) nst = M_HALT;
          else                   nd = (m_data + delta + 256) % 256;
        end else begin
          nd = (m_data + delta + 256) % 256;
        end
      end
    end
    m_st = nst; m_data = nd; m_psc = npsc; m_tc = ntc;
  endtask

  task automatic step();
    model_next();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    start = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0;
    load_val = 8'h00; prescale = 4'd0;
    step();
    checks++;
    if ({data, tc, busy, halted} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: data=%h tc=%b busy=%b halted=%b required data=ff tc=0 busy=0 halted=0",
               data, tc, busy, halted);
    end
    start = 1'b0;
    step();
    checks++;
    if (data !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: data=%h busy=%b required data=ff busy=0", data, busy);
    end
  endtask

  task automatic test_count_down();
    logic [7:0] exp_d [4];
    exp_d = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
    en = 1'b1; dir = 1'b0; mode = 2'b00; prescale = 4'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (data !== exp_d[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL count_down[%0d]: data=%h busy=%b required data=%h busy=1", i, data, busy, exp_d[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [7:0] exp_d [5];
    logic       exp_t [5];
    exp_d = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load_val = 8'h02; load = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      checks++;
      if (data !== exp_d[i] || tc !== exp_t[i]) begin
        errors++;
        $display("FAIL down_wrap[%0d]: data=%h tc=%b required data=%h tc=%b", i, data, tc, exp_d[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_up_reload();
    logic [7:0] exp_d;
    logic       exp_t;
    dir = 1'b1; mode = 2'b01; load_val = 8'hF0; load = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      load  = 1'b0;
      exp_d = (i <= 15) ? 8'(8'hF0 + i) : (i == 16 ? 8'hF0 : 8'hF1);
      exp_t = (i == 16);
      checks++;
      if (data !== exp_d || tc !== exp_t) begin
        errors++;
        $display("FAIL up_reload[%0d]: data=%h tc=%b required data=%h tc=%b", i, data, tc, exp_d, exp_t);
      end
    end
  endtask

  task automatic test_oneshot_prescale();
    logic [7:0] exp_d;
    dir = 1'b0; mode = 2'b10; prescale = 4'd3; load_val = 8'h02; load = 1'b1;
    step();
    load = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_d = (c < 4) ? 8'h02 : (c < 8) ? 8'h01 : 8'h00;
      checks++;
      if (data !== exp_d || tc !== (c == 12) || halted !== (c == 12) || busy !== (c != 12)) begin
        errors++;
        $display("FAIL oneshot[%0d]: data=%h tc=%b busy=%b halted=%b required data=%h tc=%b busy=%b halted=%b",
                 c, data, tc, busy, halted, exp_d, c == 12, c != 12, c == 12);
      end
    end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (data !== 8'h00 || tc !== 1'b0 || halted !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_hold[%0d]: data=%h tc=%b busy=%b halted=%b required data=00 tc=0 busy=0 halted=1",
                 c, data, tc, busy, halted);
      end
    end
    load_val = 8'h05; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (data !== 8'h05 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reload: data=%h busy=%b halted=%b required data=05 busy=0 halted=0", data, busy, halted);
    end
    step();
    checks++;
    if (busy !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_rerun: busy=%b halted=%b required busy=1 halted=0", busy, halted);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_d;
    mode = 2'b00; dir = 1'b0; prescale = 4'd5; load_val = 8'h37; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    checks++;
    if (data !== 8'h37 || m_psc != 2) begin
      errors++;
      $display("FAIL async_setup: data=%h model_psc=%0d required data=37 psc=2", data, m_psc);
    end
    #2 start = 1'b1;
    #1;
    model_reset();
    checks++;
    if (data !== 8'hFF || tc !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_immediate: data=%h tc=%b busy=%b halted=%b required data=ff tc=0 busy=0 halted=0",
               data, tc, busy, halted);
    end
    start = 1'b0;
    step();
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_d = (k < 6) ? 8'hFF : 8'hFE;
      checks++;
      if (data !== exp_d || busy !== 1'b1) begin
        errors++;
        $display("FAIL async_first_tick[%0d]: data=%h busy=%b required data=%h busy=1", k, data, busy, exp_d);
      end
    end
  endtask

  task automatic test_load_collision();
    prescale = 4'd0; dir = 1'b0; mode = 2'b00; load_val = 8'h01; load = 1'b1;
    step();
    load = 1'b0;
    step();
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL collision_setup: data=%h required 00", data);
    end
    load_val = 8'h10; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (data !== 8'h10 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collision: data=%h tc=%b busy=%b required data=10 tc=0 busy=1", data, tc, busy);
    end
    step();
    checks++;
    if (data !== 8'h0F || tc !== 1'b0) begin
      errors++;
      $display("FAIL collision_after: data=%h tc=%b required data=0f tc=0", data, tc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dir  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) prescale = 4'($urandom_range(0, 3));
      step();
      checks++;
      if (data !== 8'(m_data) || tc !== 1'(m_tc) || busy !== (m_st == M_RUN) || halted !== (m_st == M_HALT)) begin
        errors++;
        $display("FAIL random[%0d]: data=%h tc=%b busy=%b halted=%b required data=%h tc=%0d busy=%b halted=%b",
                 i, data, tc, busy, halted, 8'(m_data), m_tc, m_st == M_RUN, m_st == M_HALT);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_down();
    test_down_wrap();
    test_up_reload();
    test_oneshot_prescale();
    test_async_reset();
    test_load_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_timer.md
Name: updown_timer

Overview:
- Parametrised programmable counter/timer. Successor to the fixed 8-bit free-running down counter.
- Adds configurable width, up/down direction, a prescaler, three terminal-count modes (wrap, auto-reload, one-shot), synchronous load and a terminal-count pulse.
- Used as the general-purpose tick/timeout source in the datapath and the benches.

Parameters:
- WIDTH, 8, counter width in bits.
- PSC_W, 4, prescaler compare width.
- RESET_VAL, all ones ({WIDTH{1'b1}}), value `data` takes on reset.

Ports:
- clock  in  1  system clock, rising edge.
- start  in  1  reset, asynchronous, active-high. Forces all state to reset values.
- en  in  1  count enable, level-sensitive.
- dir  in  1  1 = count up, 0 = count down.
- mode  in  2  00 WRAP, 01 RELOAD, 10 ONE_SHOT, 11 reserved (behaves as WRAP).
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value; also the reload value in RELOAD mode.
- prescale  in  PSC_W  counter advances once every prescale+1 enabled cycles.
- data  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, 1 cycle wide.
- busy  out  1  1 while FSM is in RUN.
- halted  out  1  1 while FSM is in HALT.

Behaviour:
- Reset (start=1, asynchronous, any time including mid-count):
  - data=RESET_VAL, internal prescaler psc=0, tc=0, FSM=IDLE, busy=0, halted=0.
  - Effect is immediate, not at the next clock edge.
- Prescaler:
  - psc increments each clock edge while FSM=RUN.
  - tick is asserted when psc==prescale; psc returns to 0 on that same edge.
  - prescale=0 gives a tick every RUN cycle. psc holds its value in IDLE and HALT.
  - A change to prescale takes effect at the next compare.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN when en=1. RUN -> IDLE when en=0; data and psc hold.
  - RUN -> HALT on a terminal tick in ONE_SHOT mode.
  - HALT -> IDLE on load=1. en has no effect in HALT.
- Counting: on each tick in RUN, data <= data+1 when dir=1, data-1 when dir=0, modulo 2^WIDTH.
- Terminal tick: a tick where data==0 (dir=0) or data=={WIDTH{1'b1}} (dir=1). On a terminal tick:
  - WRAP: data wraps normally (00->FF down, FF->00 up). tc=1 next cycle.
  - RELOAD: data <= load_val. tc=1.
  - ONE_SHOT: data holds its terminal value, FSM -> HALT, tc=1.
- mode and dir are sampled on every tick; a mid-run change applies to the next tick.
- tc is asserted in the same cycle the post-terminal data value appears, then deasserted. Consecutive terminal ticks produce separate pulses.
- load=1 (not in reset) has priority over tick:
  - data <= load_val, psc <= 0, tc <= 0.
  - HALT -> IDLE; RUN stays RUN if en=1.
  - A load coinciding with a terminal tick suppresses that tc.
- Latency: from en rising with prescale=0, the first data change is 1 cycle after IDLE->RUN.

Decomposition:
- Package cntr_pkg holds:
  - mode encoding constants MODE_WRAP, MODE_RELOAD, MODE_ONESHOT.
  - FSM state enum S_IDLE, S_RUN, S_HALT.
- One sub-module, cntr_prescaler. Inputs: clock, start, run, clr, prescale. Output: tick.
- The FSM, terminal detection and data register live in updown_timer.

Test Plan:
- Reset then count down: start=1 gives data=FF, tc=0, busy=0. Release start, then en=1, dir=0, mode=00, prescale=0 gives data FE, FD, FC on successive cycles.
- Down wrap: load 0x02, run. data goes 02, 01, 00, FF. tc=1 exactly in the cycle data=FF, and for no other cycle.
- Up reload: load_val=F0, load, dir=1, mode=01. Sequence ends FE, FF, F0 with tc=1 at F0, then F1 with tc=0.
- One-shot with prescaler: prescale=3, load 0x02, dir=0, mode=10, en=1.
  - data changes every 4 cycles: 02, 01, 00.
  - On the next tick tc=1, data stays 00, halted=1, busy=0. Holding en=1 changes nothing.
  - load with load_val=05 gives IDLE, then RUN.
- Async reset mid-run: with psc=2 and data=37, pulse start between clock edges. data=FF and tc=0 immediately. After release, the first tick needs a full prescale+1 cycles.
- Load vs terminal collision: at data=00 on a tick with dir=0, mode=00, load=1, load_val=0x10. Result is data=10, tc stays 0, FSM stays RUN.
